// File: rtl/lsu_pkg.sv
// Shared definitions for the load/store unit: width codes, sign constants,
// FSM state type and small width helpers.
package lsu_pkg;

    localparam logic [1:0] WIDTH_BYTE = 2'b00;
    localparam logic [1:0] WIDTH_HALF = 2'b01;
    localparam logic [1:0] WIDTH_WORD = 2'b11;

    localparam logic SIGNED   = 1'b1;
    localparam logic UNSIGNED = 1'b0;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_ISSUE,
        ST_WAIT,
        ST_RESP
    } lsu_state_t;

    // Code 2'b10 is reserved and behaves exactly like a word access.
    function automatic logic [1:0] norm_width(input logic [1:0] width);
        return (width == WIDTH_BYTE || width == WIDTH_HALF) ? width : WIDTH_WORD;
    endfunction

    function automatic logic is_misaligned(input logic [1:0] width, input logic [1:0] k);
        case (norm_width(width))
            WIDTH_HALF: return k[0];
            WIDTH_WORD: return (k != 2'd0);
            default:    return 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/lsu_lane_steer.sv
// Store-data lane steering: replicate the store value to fill 32 bits, then
// rotate right by one byte per address offset so it lands on the right banks.
module lsu_lane_steer
    import lsu_pkg::*;
(
    input  logic [1:0]  i_width,
    input  logic [1:0]  i_k,
    input  logic [31:0] i_wdata,
    output logic [31:0] o_pattern
);

    logic [31:0] w_rep;

    always_comb begin
        // NOTE: default assignment first keeps this combinational block latch-free.
        w_rep = i_wdata;
        case (norm_width(i_width))
            WIDTH_BYTE: w_rep = {4{i_wdata[7:0]}};
            WIDTH_HALF: w_rep = {2{i_wdata[15:0]}};
            default:    w_rep = i_wdata;
        endcase

        case (i_k)
            2'd0:    o_pattern = w_rep;
            2'd1:    o_pattern = {w_rep[7:0],  w_rep[31:8]};
            2'd2:    o_pattern = {w_rep[15:0], w_rep[31:16]};
            default: o_pattern = {w_rep[23:0], w_rep[31:24]};
        endcase
    end

endmodule

// File: rtl/load_store_unit.sv
// Single-outstanding load/store unit driving a byte-banked data memory.
// Define LSU_MISALIGN_TRAP_EN to turn misaligned half/word accesses into error responses.
module load_store_unit
    import lsu_pkg::*;
#(
    parameter int ADDR_W   = 10,
    parameter int READ_LAT = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_we,
    input  logic [1:0]        req_width,
    input  logic              req_sign,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [31:0]       req_wdata,
    output logic              rsp_valid,
    output logic [31:0]       rsp_rdata,
    output logic              rsp_err,
    output logic [ADDR_W-1:0] mem_address,
    output logic [31:0]       mem_in,
    output logic              mem_wren,
    output logic [1:0]        mem_width,
    output logic              mem_sign,
    input  logic [31:0]       mem_out
);

    localparam logic [1:0] WAIT_LAST = 2'(READ_LAT - 1);

    lsu_state_t        r_state;
    logic              r_we;
    logic [1:0]        r_wait_cnt;
    logic              r_rsp_valid;
    logic [31:0]       r_rsp_rdata;
    logic              r_rsp_err;
    logic [ADDR_W-1:0] r_mem_address;
    logic [31:0]       r_mem_in;
    logic              r_mem_wren;
    logic [1:0]        r_mem_width;
    logic              r_mem_sign;

    logic [31:0]       w_pattern;
    logic              w_trap;

    lsu_lane_steer u_steer (
        .i_width   (req_width),
        .i_k       (req_addr[1:0]),
        .i_wdata   (req_wdata),
        .o_pattern (w_pattern)
    );

`ifdef LSU_MISALIGN_TRAP_EN
    assign w_trap = is_misaligned(req_width, req_addr[1:0]);
`else
    assign w_trap = 1'b0;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state       <= ST_IDLE;
            r_we          <= 1'b0;
            r_wait_cnt    <= 2'd0;
            r_rsp_valid   <= 1'b0;
            r_rsp_rdata   <= '0;
            r_rsp_err     <= 1'b0;
            r_mem_address <= '0;
            r_mem_in      <= '0;
            r_mem_wren    <= 1'b0;
            r_mem_width   <= '0;
            r_mem_sign    <= 1'b0;
        end else begin
            // NOTE: sequential state uses non-blocking assignments so every register sees pre-edge values.
            case (r_state)
                ST_IDLE: begin
                    if (req_valid) begin
                        r_mem_address <= req_addr;
                        r_mem_width   <= norm_width(req_width);
                        r_mem_sign    <= req_sign;
                        r_mem_in      <= w_pattern;
                        r_rsp_rdata   <= '0;
                        if (w_trap) begin
                            r_rsp_err   <= 1'b1;
                            r_rsp_valid <= 1'b1;
                            r_state     <= ST_RESP;
                        end else begin
                            r_we        <= req_we;
                            r_mem_wren  <= req_we;
                            r_state     <= ST_ISSUE;
                        end
                    end
                end
                ST_ISSUE: begin
                    r_mem_wren <= 1'b0;
                    if (r_we) begin
                        r_rsp_valid <= 1'b1;
                        r_state     <= ST_RESP;
                    end else begin
                        r_wait_cnt  <= WAIT_LAST;
                        r_state     <= ST_WAIT;
                    end
                end
                ST_WAIT: begin
                    // Memory already extends the data, so mem_out is captured as-is.
                    if (r_wait_cnt == 2'd0) begin
                        r_rsp_rdata <= mem_out;
                        r_rsp_valid <= 1'b1;
                        r_state     <= ST_RESP;
                    end else begin
                        r_wait_cnt  <= r_wait_cnt - 2'd1;
                    end
                end
                ST_RESP: begin
                    r_rsp_valid <= 1'b0;
                    r_rsp_err   <= 1'b0;
                    r_rsp_rdata <= '0;
                    r_state     <= ST_IDLE;
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    assign req_ready   = (r_state == ST_IDLE);
    assign rsp_valid   = r_rsp_valid;
    assign rsp_rdata   = r_rsp_rdata;
    assign rsp_err     = r_rsp_err;
    assign mem_address = r_mem_address;
    assign mem_in      = r_mem_in;
    assign mem_wren    = r_mem_wren;
    assign mem_width   = r_mem_width;
    assign mem_sign    = r_mem_sign;

endmodule

// File: tb/tb_load_store_unit.sv
// Self-checking bench for load_store_unit: byte-addressed memory model plus a
// shadow reference memory updated from the access rules with plain arithmetic.
module tb_load_store_unit;
    import lsu_pkg::*;

    localparam int ADDR_W    = 10;
    localparam int READ_LAT  = 2;
    localparam int MEM_BYTES = 1 << ADDR_W;
    localparam int MAX_EDGES = 20;
`ifdef LSU_MISALIGN_TRAP_EN
    localparam bit TRAP_EN = 1'b1;
`else
    localparam bit TRAP_EN = 1'b0;
`endif

    logic              clk = 1'b0;
    logic              rst;
    logic              req_valid, req_ready, req_we, req_sign;
    logic [1:0]        req_width;
    logic [ADDR_W-1:0] req_addr;
    logic [31:0]       req_wdata;
    logic              rsp_valid, rsp_err;
    logic [31:0]       rsp_rdata;
    logic [ADDR_W-1:0] mem_address;
    logic [31:0]       mem_in, mem_out;
    logic              mem_wren, mem_sign;
    logic [1:0]        mem_width;

    int n_tests = 0;
    int n_fail  = 0;

    typedef struct {
        int                edges;
        int                wren_cycles;
        logic [31:0]       rdata;
        logic              err;
        logic [31:0]       mem_in;
        logic [ADDR_W-1:0] mem_address;
        logic [1:0]        mem_width;
        logic              mem_sign;
        bit                hold_ok;
        bit                ready_ok;
        bit                one_cycle;
        bit                timeout;
    } obs_t;

    load_store_unit #(.ADDR_W(ADDR_W), .READ_LAT(READ_LAT)) dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
        .req_width(req_width), .req_sign(req_sign), .req_addr(req_addr), .req_wdata(req_wdata),
        .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
        .mem_address(mem_address), .mem_in(mem_in), .mem_wren(mem_wren),
        .mem_width(mem_width), .mem_sign(mem_sign), .mem_out(mem_out)
    );

    always #5 clk = ~clk;

    // ---------------- reference rules ----------------
    function automatic int nbytes(input logic [1:0] w);
        return (w == 2'b00) ? 1 : (w == 2'b01) ? 2 : 4;
    endfunction

    function automatic logic [7:0] init_byte(input int a);
        return 8'((a * 151 + 29) ^ (a >> 2));
    endfunction

    function automatic bit exp_trap(input logic [1:0] w, input int addr);
        return TRAP_EN && ((addr % nbytes(w)) != 0);
    endfunction

    function automatic int exp_edges(input logic we, input bit trap);
        return trap ? 1 : (we ? 2 : READ_LAT + 2);
    endfunction

    function automatic logic [1:0] exp_width(input logic [1:0] w);
        return (w == 2'b10) ? 2'b11 : w;
    endfunction

    // Fill 32 bits by repeating the store value, then rotate right by 8*offset.
    function automatic logic [31:0] exp_mem_in(input logic [1:0] w, input int addr, input logic [31:0] wdata);
        logic [31:0] p;
        logic [63:0] two;
        int nb = nbytes(w);
        for (int i = 0; i < 4; i++) p[8*i +: 8] = wdata[8*(i % nb) +: 8];
        two = {p, p} >> (8 * (addr % 4));
        return two[31:0];
    endfunction

    function automatic logic [31:0] extend(input logic [31:0] raw, input int nb, input logic sgn);
        logic [31:0] v = raw;
        if (sgn && raw[8*nb-1])
            for (int i = nb; i < 4; i++) v[8*i +: 8] = 8'hFF;
        return v;
    endfunction

    // ---------------- memory model ----------------
    logic [7:0]  shadow [MEM_BYTES];
    logic [7:0]  tb_mem [MEM_BYTES];
    logic [31:0] rd_pipe [READ_LAT];
    bit          mem_init_done = 1'b0;

    function automatic logic [31:0] model_load(input int addr, input logic [1:0] w, input logic sgn);
        logic [31:0] v = '0;
        for (int i = 0; i < nbytes(w); i++) v[8*i +: 8] = shadow[(addr + i) % MEM_BYTES];
        return extend(v, nbytes(w), sgn);
    endfunction

    function automatic void model_store(input int addr, input logic [1:0] w, input logic [31:0] wdata);
        for (int i = 0; i < nbytes(w); i++) shadow[(addr + i) % MEM_BYTES] = wdata[8*i +: 8];
    endfunction

    function automatic logic [31:0] bank_read(input int addr, input logic [1:0] w, input logic sgn);
        logic [31:0] v = '0;
        for (int i = 0; i < nbytes(w); i++) v[8*i +: 8] = tb_mem[(addr + i) % MEM_BYTES];
        return extend(v, nbytes(w), sgn);
    endfunction

    // Byte i of the access sits on lane (i - offset) mod 4 of mem_in.
    always @(posedge clk) begin
        if (!mem_init_done) begin
            for (int a = 0; a < MEM_BYTES; a++) tb_mem[a] <= init_byte(a);
            mem_init_done <= 1'b1;
        end else if (mem_wren) begin
            for (int i = 0; i < nbytes(mem_width); i++)
                tb_mem[(int'(mem_address) + i) % MEM_BYTES] <=
                    mem_in[8*((i - int'(mem_address[1:0])) & 3) +: 8];
        end
        rd_pipe[0] <= bank_read(int'(mem_address), mem_width, mem_sign);
        for (int j = 1; j < READ_LAT; j++) rd_pipe[j] <= rd_pipe[j-1];
    end
    assign mem_out = rd_pipe[READ_LAT-1];

    // ---------------- access driver ----------------
    task automatic run_access(input logic we, input logic [1:0] width, input logic sgn,
                              input logic [ADDR_W-1:0] addr, input logic [31:0] wdata,
                              output obs_t o);
        int  n;
        bit  done;
        o.edges = 0; o.wren_cycles = 0; o.rdata = '0; o.err = 1'b0;
        o.hold_ok = 1'b1; o.ready_ok = 1'b1; o.one_cycle = 1'b0; o.timeout = 1'b0;
        req_valid = 1'b1; req_we = we; req_width = width; req_sign = sgn;
        req_addr = addr; req_wdata = wdata;
        @(posedge clk);
        @(negedge clk);
        // Junk on the request lines must be ignored while busy.
        req_valid = 1'b0; req_we = 1'($urandom); req_width = 2'($urandom);
        req_sign = 1'($urandom); req_addr = ADDR_W'($urandom); req_wdata = $urandom;
        o.mem_in = mem_in; o.mem_address = mem_address; o.mem_width = mem_width; o.mem_sign = mem_sign;
        n = 1;
        done = 1'b0;
        while (!done) begin
            if (mem_wren === 1'b1) o.wren_cycles++;
            if (mem_address !== o.mem_address || mem_width !== o.mem_width || mem_sign !== o.mem_sign)
                o.hold_ok = 1'b0;
            if (rsp_valid === 1'b1) begin
                done = 1'b1;
            end else begin
                if (req_ready !== 1'b0) o.ready_ok = 1'b0;
                if (n >= MAX_EDGES) begin
                    o.timeout = 1'b1;
                    done = 1'b1;
                end else begin
                    @(negedge clk);
                    n++;
                end
            end
        end
        o.edges = n; o.rdata = rsp_rdata; o.err = rsp_err;
        @(negedge clk);
        o.one_cycle = (rsp_valid === 1'b0) && (req_ready === 1'b1);
        if (mem_wren === 1'b1) o.wren_cycles++;
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        @(negedge clk);
        @(negedge clk);
        n_tests++;
        if ({mem_address, mem_in, mem_wren, mem_width, mem_sign} !== '0) begin
            n_fail++;
            $display("FAIL reset mem_outputs: got addr=%h in=%h wren=%b width=%b sign=%b, required all 0",
                     mem_address, mem_in, mem_wren, mem_width, mem_sign);
        end
        n_tests++;
        if ({rsp_valid, rsp_rdata, rsp_err} !== '0) begin
            n_fail++;
            $display("FAIL reset rsp: got valid=%b rdata=%h err=%b, required 0", rsp_valid, rsp_rdata, rsp_err);
        end
        n_tests++;
        if (req_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL reset req_ready: got %b required 1", req_ready);
        end
        rst = 1'b0;
    endtask

    task automatic test_store_steering();
        obs_t o;
        bit   t;
        // Word store at 0x005.
        t = exp_trap(2'b11, 'h005);
        run_access(1'b1, 2'b11, 1'b0, 10'h005, 32'h1122_3344, o);
        if (!t) model_store('h005, 2'b11, 32'h1122_3344);
        n_tests++;
        if (!t && o.mem_in !== exp_mem_in(2'b11, 'h005, 32'h1122_3344)) begin
            n_fail++;
            $display("FAIL word_store mem_in: got %h required %h", o.mem_in, exp_mem_in(2'b11, 'h005, 32'h1122_3344));
        end
        n_tests++;
        if (o.wren_cycles !== (t ? 0 : 1)) begin
            n_fail++;
            $display("FAIL word_store wren_cycles: got %0d required %0d", o.wren_cycles, t ? 0 : 1);
        end
        n_tests++;
        if (o.edges !== exp_edges(1'b1, t)) begin
            n_fail++;
            $display("FAIL word_store latency: got %0d required %0d", o.edges, exp_edges(1'b1, t));
        end
        // Half store at 0x003.
        t = exp_trap(2'b01, 'h003);
        run_access(1'b1, 2'b01, 1'b0, 10'h003, 32'h0000_BEEF, o);
        if (!t) model_store('h003, 2'b01, 32'h0000_BEEF);
        n_tests++;
        if (!t && o.mem_in !== exp_mem_in(2'b01, 'h003, 32'h0000_BEEF)) begin
            n_fail++;
            $display("FAIL half_store mem_in: got %h required %h", o.mem_in, exp_mem_in(2'b01, 'h003, 32'h0000_BEEF));
        end
        n_tests++;
        if (o.mem_width !== 2'b01) begin
            n_fail++;
            $display("FAIL half_store mem_width: got %b required 01", o.mem_width);
        end
        n_tests++;
        if (o.err !== t) begin
            n_fail++;
            $display("FAIL half_store rsp_err: got %b required %b", o.err, t);
        end
    endtask

    task automatic test_load();
        obs_t o;
        run_access(1'b1, 2'b00, 1'b0, 10'h002, 32'h0000_0080, o);
        model_store('h002, 2'b00, 32'h0000_0080);
        run_access(1'b0, 2'b00, SIGNED, 10'h002, 32'h0, o);
        n_tests++;
        if (o.rdata !== model_load('h002, 2'b00, SIGNED)) begin
            n_fail++;
            $display("FAIL signed_byte_load rdata: got %h required %h", o.rdata, model_load('h002, 2'b00, SIGNED));
        end
        n_tests++;
        if (o.edges !== READ_LAT + 2) begin
            n_fail++;
            $display("FAIL signed_byte_load latency: got %0d required %0d", o.edges, READ_LAT + 2);
        end
        n_tests++;
        if (!o.ready_ok || !o.one_cycle) begin
            n_fail++;
            $display("FAIL signed_byte_load handshake: got ready_low=%b one_cycle=%b required 1 1", o.ready_ok, o.one_cycle);
        end
        run_access(1'b0, 2'b01, UNSIGNED, 10'h002, 32'h0, o);
        n_tests++;
        if (o.rdata !== model_load('h002, 2'b01, UNSIGNED)) begin
            n_fail++;
            $display("FAIL unsigned_half_load rdata: got %h required %h", o.rdata, model_load('h002, 2'b01, UNSIGNED));
        end
    endtask

    task automatic test_misalign();
        obs_t        o;
        bit          t;
        logic [31:0] exp;
        t = exp_trap(2'b11, 'h001);
        run_access(1'b0, 2'b11, 1'b0, 10'h001, 32'h0, o);
        exp = t ? 32'h0 : model_load('h001, 2'b11, 1'b0);
        n_tests++;
        if (o.edges !== exp_edges(1'b0, t) || o.err !== t) begin
            n_fail++;
            $display("FAIL misaligned_load latency/err: got %0d/%b required %0d/%b", o.edges, o.err, exp_edges(1'b0, t), t);
        end
        n_tests++;
        if (o.rdata !== exp || o.wren_cycles !== 0) begin
            n_fail++;
            $display("FAIL misaligned_load rdata/wren: got %h/%0d required %h/0", o.rdata, o.wren_cycles, exp);
        end
        // Word store across the top row boundary, then read it back.
        t = exp_trap(2'b11, 'h3FE);
        run_access(1'b1, 2'b11, 1'b0, 10'h3FE, 32'hCAFE_F00D, o);
        if (!t) model_store('h3FE, 2'b11, 32'hCAFE_F00D);
        n_tests++;
        if (o.wren_cycles !== (t ? 0 : 1) || o.err !== t) begin
            n_fail++;
            $display("FAIL wrap_store wren/err: got %0d/%b required %0d/%b", o.wren_cycles, o.err, t ? 0 : 1, t);
        end
        run_access(1'b0, 2'b11, 1'b0, 10'h3FE, 32'h0, o);
        exp = t ? 32'h0 : model_load('h3FE, 2'b11, 1'b0);
        n_tests++;
        if (o.rdata !== exp || o.err !== t) begin
            n_fail++;
            $display("FAIL wrap_load rdata/err: got %h/%b required %h/%b", o.rdata, o.err, exp, t);
        end
    endtask

    task automatic test_back_to_back();
        logic [5:0]  wren_mask = '0;
        logic [5:0]  valid_mask = '0;
        logic [31:0] in4 = '0;
        logic [31:0] d1 = $urandom;
        logic [31:0] d2 = $urandom;
        req_valid = 1'b1; req_we = 1'b1; req_width = 2'b11; req_sign = 1'b0;
        req_addr = 10'h020; req_wdata = d1;
        for (int n = 1; n <= 6; n++) begin
            @(negedge clk);
            wren_mask[n-1]  = (mem_wren === 1'b1);
            valid_mask[n-1] = (rsp_valid === 1'b1);
            if (n == 1) begin
                req_width = 2'b01; req_addr = 10'h026; req_wdata = d2;
            end
            if (n == 4) begin
                in4 = mem_in;
                req_valid = 1'b0;
            end
        end
        model_store('h020, 2'b11, d1);
        model_store('h026, 2'b01, d2);
        // Accepts on edges 1 and 4 (edge 3 leaves RESP), responses on edges 2 and 5.
        n_tests++;
        if (wren_mask !== 6'b001001) begin
            n_fail++;
            $display("FAIL back_to_back wren_mask: got %b required 001001", wren_mask);
        end
        n_tests++;
        if (valid_mask !== 6'b010010) begin
            n_fail++;
            $display("FAIL back_to_back rsp_valid_mask: got %b required 010010", valid_mask);
        end
        n_tests++;
        if (in4 !== exp_mem_in(2'b01, 'h026, d2)) begin
            n_fail++;
            $display("FAIL back_to_back second mem_in: got %h required %h", in4, exp_mem_in(2'b01, 'h026, d2));
        end
    endtask

    task automatic test_reset_mid_op();
        int n;
        int seen_valid = 0;
        // Abort a store while mem_wren is high.
        req_valid = 1'b1; req_we = 1'b1; req_width = 2'b11; req_sign = 1'b0;
        req_addr = 10'h030; req_wdata = 32'h1234_5678;
        @(posedge clk);
        @(negedge clk);
        req_valid = 1'b0;
        rst = 1'b1;
        #1;
        n_tests++;
        if (mem_wren !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_in_issue mem_wren: got %b required 0", mem_wren);
        end
        @(negedge clk);
        rst = 1'b0;
        // Abort a load in WAIT.
        req_valid = 1'b1; req_we = 1'b0; req_width = 2'b11; req_addr = 10'h010;
        @(posedge clk);
        @(negedge clk);
        req_valid = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        #1;
        n_tests++;
        if ({mem_address, mem_in, mem_wren, mem_width, mem_sign, rsp_valid, rsp_rdata, rsp_err} !== '0
            || req_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL reset_in_wait outputs: got addr=%h rdata=%h valid=%b ready=%b, required 0/0/0/1",
                     mem_address, rsp_rdata, rsp_valid, req_ready);
        end
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            if (rsp_valid === 1'b1) seen_valid++;
        end
        rst = 1'b0;
        req_valid = 1'b1; req_we = 1'b1; req_width = 2'b11; req_addr = 10'h040; req_wdata = 32'hA5A5_0F0F;
        @(posedge clk);
        @(negedge clk);
        req_valid = 1'b0;
        n_tests++;
        if (mem_wren !== 1'b1 || mem_address !== 10'h040) begin
            n_fail++;
            $display("FAIL post_reset accept: got wren=%b addr=%h required 1 040", mem_wren, mem_address);
        end
        n = 1;
        while (rsp_valid !== 1'b1 && n < MAX_EDGES) begin
            @(negedge clk);
            n++;
        end
        n_tests++;
        if (n !== 2 || seen_valid !== 0) begin
            n_fail++;
            $display("FAIL post_reset store: got latency=%0d stray_valid=%0d required 2 0", n, seen_valid);
        end
        @(negedge clk);
        model_store('h040, 2'b11, 32'hA5A5_0F0F);
    endtask

    task automatic test_random();
        obs_t              o;
        bit                t;
        logic              we, sgn;
        logic [1:0]        w;
        logic [ADDR_W-1:0] a;
        logic [31:0]       d, exp_rd;
        for (int k = 0; k < 60; k++) begin
            we  = 1'($urandom);
            w   = 2'($urandom);
            sgn = 1'($urandom);
            a   = ($urandom_range(0, 3) == 0) ? ADDR_W'($urandom_range(MEM_BYTES - 4, MEM_BYTES - 1))
                                              : ADDR_W'($urandom_range(0, 63));
            d   = $urandom;
            t   = exp_trap(w, int'(a));
            run_access(we, w, sgn, a, d, o);
            exp_rd = (we || t) ? 32'h0 : model_load(int'(a), w, sgn);
            if (we && !t) model_store(int'(a), w, d);
            n_tests++;
            if (o.timeout || o.edges !== exp_edges(we, t)) begin
                n_fail++;
                $display("FAIL rand[%0d] latency: got %0d required %0d", k, o.edges, exp_edges(we, t));
            end
            n_tests++;
            if (o.rdata !== exp_rd || o.err !== t) begin
                n_fail++;
                $display("FAIL rand[%0d] rdata/err we=%b w=%b a=%h: got %h/%b required %h/%b",
                         k, we, w, a, o.rdata, o.err, exp_rd, t);
            end
            n_tests++;
            if (o.wren_cycles !== ((we && !t) ? 1 : 0)) begin
                n_fail++;
                $display("FAIL rand[%0d] wren_cycles: got %0d required %0d", k, o.wren_cycles, (we && !t) ? 1 : 0);
            end
            n_tests++;
            if (o.mem_address !== a || o.mem_width !== exp_width(w) || o.mem_sign !== sgn) begin
                n_fail++;
                $display("FAIL rand[%0d] mem_ctrl: got %h/%b/%b required %h/%b/%b",
                         k, o.mem_address, o.mem_width, o.mem_sign, a, exp_width(w), sgn);
            end
            if (we && !t) begin
                n_tests++;
                if (o.mem_in !== exp_mem_in(w, int'(a), d)) begin
                    n_fail++;
                    $display("FAIL rand[%0d] mem_in: got %h required %h", k, o.mem_in, exp_mem_in(w, int'(a), d));
                end
            end
            n_tests++;
            if (!o.hold_ok || !o.ready_ok || !o.one_cycle) begin
                n_fail++;
                $display("FAIL rand[%0d] protocol: got hold=%b ready_low=%b one_cycle=%b required 1 1 1",
                         k, o.hold_ok, o.ready_ok, o.one_cycle);
            end
        end
    endtask

    initial begin
        rst = 1'b1;
        req_valid = 1'b0; req_we = 1'b0; req_width = 2'b00; req_sign = 1'b0;
        req_addr = '0; req_wdata = '0;
        for (int a = 0; a < MEM_BYTES; a++) shadow[a] = init_byte(a);
        test_reset();
        test_store_steering();
        test_load();
        test_misalign();
        test_back_to_back();
        test_reset_mid_op();
        test_random();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, time %0t", $time);
        $fatal(1, "watchdog expired");
    end

endmodule

// File: doc/load_store_unit.md
LOAD_STORE_UNIT -- requirements
Module: load_store_unit

Interface
REQ-001 SHALL have parameter ADDR_W, default 10: byte-address width of request and memory ports.
REQ-002 SHALL have parameter READ_LAT, default 1, legal range 1-3: cycles from memory address capture to valid mem_out.
REQ-003 SHALL have port clk  input  1  sole clock, rising edge.
REQ-004 SHALL have port rst  input  1  reset, asynchronous, active-high.
REQ-005 SHALL have port req_valid  input  1  pipeline access request.
REQ-006 SHALL have port req_ready  output  1  unit accepts request this cycle.
REQ-007 SHALL have port req_we  input  1  1=store, 0=load.
REQ-008 SHALL have port req_width  input  2  00 byte, 01 half, 11 word; 10 treated as word.
REQ-009 SHALL have port req_sign  input  1  1=signed load extension.
REQ-010 SHALL have port req_addr  input  ADDR_W  byte address.
REQ-011 SHALL have port req_wdata  input  32  store value, right-justified.
REQ-012 SHALL have port rsp_valid  output  1  one-cycle completion strobe.
REQ-013 SHALL have port rsp_rdata  output  32  load result; 0 for stores and errors.
REQ-014 SHALL have port rsp_err  output  1  misaligned-access error, qualified by rsp_valid.
REQ-015 SHALL have ports mem_address (output, ADDR_W), mem_in (output, 32), mem_wren (output, 1), mem_width (output, 2), mem_sign (output, 1), mem_out (input, 32), which drive the byte-banked data memory.

Function
REQ-016 SHALL implement FSM IDLE, ISSUE, WAIT, RESP; req_ready = 1 only in IDLE.
REQ-017 SHALL accept a request on a clk edge where req_valid and req_ready are both 1, registering address, width, sign and steered data onto the mem_* outputs.
REQ-018 SHALL hold mem_address, mem_width and mem_sign stable from the accept edge until return to IDLE.
REQ-019 SHALL steer store data with k = addr[1:0]: mem_in = rotate-right-by-8k of the pattern.
REQ-020 SHALL form that pattern as word: wdata; half: {wdata[15:0], wdata[15:0]}; byte: wdata[7:0] replicated 4x.
REQ-021 SHALL, for a store, assert mem_wren in ISSUE only (exactly one cycle), then go ISSUE->RESP.
REQ-022 SHALL, for a load, go ISSUE->WAIT, stay READ_LAT cycles, sample mem_out into rsp_rdata on the last WAIT edge, then go to RESP.
REQ-023 SHALL pass mem_out unmodified; sign/zero extension is done by the memory from mem_sign/mem_width.
REQ-024 SHALL assert rsp_valid for exactly one cycle in RESP, then go RESP->IDLE.
REQ-025 SHALL give load latency of READ_LAT+2 edges (accept to rsp_valid high) and store latency of 2 edges.
REQ-026 SHALL ignore req_* while not in IDLE; there is no pipelining of requests.
REQ-027 SHALL let bank-row wrap at the top address (misaligned word at last row) occur silently with no error.

Reset
REQ-028 SHALL on rst force IDLE immediately, with all mem_* outputs, rsp_valid, rsp_rdata and rsp_err at 0, and req_ready at 1.
REQ-029 SHALL on rst mid-operation abort the access with no rsp_valid; mem_wren SHALL drop asynchronously.

Configuration
REQ-030 SHALL, with LSU_MISALIGN_TRAP_EN defined, treat half with addr[0]=1 and word with addr[1:0]!=0 as errors: IDLE->RESP directly, mem_wren never asserted, rsp_err=1, rsp_rdata=0.
REQ-031 SHALL, without LSU_MISALIGN_TRAP_EN, issue all accesses normally and tie rsp_err to 0.

Structure
REQ-032 SHALL take width codes (BYTE/HALF/WORD), SIGNED/UNSIGNED constants and the FSM state typedef from shared package lsu_pkg.
REQ-033 SHALL place data steering in one combinational sub-module lsu_lane_steer (inputs: width, k, wdata; output: mem_in pattern).

Verification
REQ-034 SHALL cover: word store 0x11223344 at addr 0x005 (trap off) -> mem_in=0x44112233, mem_wren high 1 cycle, rsp_valid 2 edges after accept.
REQ-035 SHALL cover: half store 0xBEEF at addr 0x003 (trap off) -> mem_in=0xEFBEEFBE, mem_width=01, rsp_err=0.
REQ-036 SHALL cover: signed byte load at 0x002, memory model returns 0xFFFFFF80 -> rsp_rdata=0xFFFFFF80, rsp_valid at READ_LAT+2 edges, req_ready low meanwhile.
REQ-037 SHALL cover: word load at 0x001 with LSU_MISALIGN_TRAP_EN -> rsp_valid 1 edge after accept, rsp_err=1, rsp_rdata=0, mem_wren never 1.
REQ-038 SHALL cover: rst pulsed during WAIT -> outputs 0 immediately, no rsp_valid, next request accepted on first edge after release.
REQ-039 SHALL cover: req_valid held across two queued stores -> second accepted only on the edge after RESP, no mem_wren overlap.
